cpu_run_ctrl: RTL and testbench

- Sequencer that loads a program image into CPU program memory from a valid/ready word stream.
- Pads the unused program memory with a fill word, then releases the CPU for a bounded number of cycles.
- Freezes the CPU on halt or cycle limit, then captures one result word from data memory.
- Sits between the host/bench side and mod_cpu, replacing open-ended fixed-time runs with a handshaked load/run/report flow.

---
 rtl/cpu_run_ctrl.sv | 149 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: handshaked load/pad/run/report sequencer for a small CPU.
// Loads a program image from a valid/ready stream into program memory, pads the
// remaining addresses with PAD_WORD, runs the CPU for a bounded number of cycles,
// then freezes it and captures one result word from data memory.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i                   begin load+run (accepted in IDLE/DONE only)
//   prog_len_i, run_cycles_i  image length and cycle limit (0 = no limit)
//   in_valid_i/in_ready_o/in_data_i  load stream
//   rom_we_o/rom_waddr_o/rom_wdata_o program memory write port (combinational)
//   cpu_reset_o, cpu_run_o, cpu_halt_i CPU control
//   ram_raddr_o, ram_rdata_i  result read port (1-cycle latency)
//   busy_o, done_o, timeout_o, result_o status and captured result
module cpu_run_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RAM_AW = 8,
    parameter logic [RAM_AW-1:0] RES_ADDR = '0,
    parameter logic [DATA_W-1:0] PAD_WORD = '0,
    parameter int CYC_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   prog_len_i,
    input  logic [CYC_W-1:0]  run_cycles_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [DATA_W-1:0] rom_wdata_o,
    output logic              cpu_reset_o,
    output logic              cpu_run_o,
    input  logic              cpu_halt_i,
    output logic [RAM_AW-1:0] ram_raddr_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] result_o
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_A = 1;
    localparam logic [CYC_W-1:0] ONE_C = 1;

    typedef enum logic [2:0] {IDLE, LOAD, PAD, RUN, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   addr_q, len_q, len_in;
    logic [CYC_W-1:0]  cyc_q, limit_q;
    logic              timeout_q;
    logic [DATA_W-1:0] result_q;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_run_q, cpu_run_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              accept, beat, last_load, pad_end, lim_hit;

    assign accept    = start_i && (state_q == IDLE || state_q == DONE);
    assign len_in    = prog_len_i > DEPTH ? DEPTH : prog_len_i;
    assign beat      = state_q == LOAD && in_valid_i && in_ready_q;
    assign last_load = beat && addr_q == len_q - ONE_A;
    assign pad_end   = state_q == PAD && addr_q[ADDR_W-1:0] == '1;
    assign lim_hit   = limit_q != '0 && cyc_q == limit_q - ONE_C;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = len_in != '0 ? LOAD : PAD;
            LOAD:       if (last_load) state_d = len_q != DEPTH ? PAD : RUN;
            PAD:        if (pad_end) state_d = RUN;
            RUN:        if (cpu_halt_i || lim_hit) state_d = WAIT;
            WAIT:       state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Registered outputs decoded from the next state; the CPU stays frozen
    // (not reset) through WAIT and the first DONE cycle so RAM is untouched.
    always_comb begin
        in_ready_d  = state_d == LOAD;
        busy_d      = state_d inside {LOAD, PAD, RUN, WAIT};
        done_d      = state_d == DONE;
        cpu_run_d   = state_d == RUN;
        cpu_reset_d = !(state_d == RUN || state_d == WAIT || (state_d == DONE && state_q == WAIT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_run_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_run_q   <= cpu_run_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // Datapath: address/cycle counters, latched parameters, status and result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            len_q     <= '0;
            limit_q   <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                len_q     <= len_in;
                limit_q   <= run_cycles_i;
                addr_q    <= '0;
                timeout_q <= 1'b0;
                result_q  <= '0;
            end else if (beat || state_q == PAD) begin
                addr_q <= addr_q + ONE_A;
            end
            cyc_q <= state_q != RUN ? '0 : (cyc_q == '1 ? cyc_q : cyc_q + ONE_C);
            if (state_q == RUN && !cpu_halt_i && lim_hit) timeout_q <= 1'b1;
            if (state_q == WAIT) result_q <= ram_rdata_i;
        end
    end

    assign rom_we_o    = beat || state_q == PAD;
    assign rom_waddr_o = addr_q[ADDR_W-1:0];
    assign rom_wdata_o = state_q == LOAD ? in_data_i : (state_q == PAD ? PAD_WORD : '0);
    assign in_ready_o  = in_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cpu_run_o   = cpu_run_q;
    assign cpu_reset_o = cpu_reset_q;
    assign timeout_o   = timeout_q;
    assign result_o    = result_q;
    assign ram_raddr_o = RES_ADDR;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl with a ROM write scoreboard.
module tb_cpu_run_ctrl;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] PADW = 16'hBEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic [CW-1:0] run_cycles = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [DW-1:0] rom_wdata;
    logic          cpu_reset, cpu_run;
    logic          cpu_halt = 1'b0;
    logic [7:0]    ram_raddr;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] ram0 = '0;
    logic          busy, done, timeout;
    logic [DW-1:0] result;

    cpu_run_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_AW(8), .RES_ADDR(8'd0),
                   .PAD_WORD(PADW), .CYC_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .prog_len_i(prog_len),
        .run_cycles_i(run_cycles), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .rom_we_o(rom_we), .rom_waddr_o(rom_waddr),
        .rom_wdata_o(rom_wdata), .cpu_reset_o(cpu_reset), .cpu_run_o(cpu_run),
        .cpu_halt_i(cpu_halt), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .result_o(result)
    );

    always #5 clk = ~clk;
    // Data memory stand-in: synchronous read with one cycle of latency.
    always @(posedge clk) ram_rdata <= ram0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    typedef struct {
        int plen;
        int rcyc;
        int halt_at;
        bit gap;
        bit poke;
        logic [DW-1:0] ram;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vt[8];
    int   checks = 0;
    int   fails = 0;

    function automatic logic [DW-1:0] word(input int i);
        return 16'(32'h5A00 + i * 291);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_rom_we"}, rom_we, 0);
        chk({tag, "_rom_waddr"}, rom_waddr, 0);
        chk({tag, "_rom_wdata"}, rom_wdata, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_cpu_run"}, cpu_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_ram_raddr"}, ram_raddr, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int  len = v.plen > DEPTH ? DEPTH : v.plen;
        int  k = 0, runcnt = 0, ldcnt = 0, padcnt = 0, last_run = -10, done_c = -1;
        bit  fin = 0;
        bit  halt_path = v.halt_at >= 0 && (v.rcyc == 0 || v.halt_at + 1 <= v.rcyc);
        int  exp_run = halt_path ? v.halt_at + 1 : v.rcyc;
        logic rst_at_done = 1'b1;
        wr_t w;
        ram0 = v.ram;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w.a = AW'(i);
            w.d = i < len ? word(i) : PADW;
            exp_q.push_back(w);
        end
        @(negedge clk);
        start = 1'b1;
        prog_len = (AW + 1)'(v.plen);
        run_cycles = CW'(v.rcyc);
        in_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2000 && !fin; c++) begin
            in_valid = k < len && (!v.gap || c % 2 == 0);
            in_data = k < len ? word(k) : '0;
            start = v.poke && cpu_run && runcnt == 2;
            cpu_halt = cpu_run && runcnt == v.halt_at;
            #1;
            if (c == 0) begin
                chk("accept_done_clr", done, 0);
                chk("accept_res_clr", result, 0);
                chk("accept_to_clr", timeout, 0);
                chk("accept_busy", busy, 1);
            end
            if (rom_we) begin
                if (exp_q.size() == 0) chk("rom_extra_write", 1, 0);
                else begin
                    w = exp_q.pop_front();
                    chk("rom_waddr", rom_waddr, w.a);
                    chk("rom_wdata", rom_wdata, w.d);
                end
                if (!in_ready) padcnt++;
            end else if (in_ready && exp_q.size() > 0) chk("rom_waddr_hold", rom_waddr, exp_q[0].a);
            if (in_ready) ldcnt++;
            if (in_valid && in_ready) k++;
            if (cpu_run) begin
                chk("run_cpu_reset", cpu_reset, 0);
                runcnt++;
                last_run = c;
            end
            if (done) begin
                fin = 1;
                done_c = c;
                rst_at_done = cpu_reset;
            end
            @(negedge clk);
        end
        start = 1'b0;
        cpu_halt = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("finished", fin, 1);
        chk("run_cycles", runcnt, exp_run);
        chk("timeout", timeout, !halt_path);
        chk("result", result, v.ram);
        chk("writes_left", exp_q.size(), 0);
        chk("load_cycles", ldcnt, v.gap ? (len > 0 ? 2 * len - 1 : 0) : len);
        chk("pad_cycles", padcnt, DEPTH - len);
        chk("done_latency", done_c - last_run, 2);
        chk("done_entry_frozen", rst_at_done, 0);
        chk("done_then_reset", cpu_reset, 1);
        chk("done_held", done, 1);
        chk("busy_in_done", busy, 0);
    endtask

    initial begin
        vt[0] = '{plen: 35, rcyc: 500, halt_at: 119, gap: 0, poke: 1, ram: 16'd42};
        vt[1] = '{plen: 35, rcyc: 10,  halt_at: -1,  gap: 0, poke: 0, ram: 16'h0007};
        vt[2] = '{plen: 4,  rcyc: 50,  halt_at: 5,   gap: 1, poke: 0, ram: 16'h1234};
        vt[3] = '{plen: 0,  rcyc: 20,  halt_at: 3,   gap: 0, poke: 0, ram: 16'hA5A5};
        vt[4] = '{plen: 64, rcyc: 0,   halt_at: 30,  gap: 0, poke: 0, ram: 16'h0F0F};
        vt[5] = '{plen: 35, rcyc: 8,   halt_at: 7,   gap: 0, poke: 0, ram: 16'h00C3};
        vt[6] = '{plen: 100, rcyc: 5,  halt_at: -1,  gap: 0, poke: 0, ram: 16'h7777};
        vt[7] = '{plen: 1,  rcyc: 1,   halt_at: -1,  gap: 0, poke: 0, ram: 16'hFFFF};
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run_vec(vt[i]);
        // Asynchronous reset in the middle of a load at addr 5
        @(negedge clk);
        start = 1'b1;
        prog_len = 7'd20;
        run_cycles = 16'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && !(in_ready && rom_waddr == 6'd5); c++) begin
            in_valid = 1'b1;
            in_data = word(c);
            @(negedge clk);
        end
        chk("midload_addr5", rom_waddr, 5);
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vt[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
